// File: rtl/qos_pkg.sv
// Shared constants and helpers for the QoS output arbiter.
// Word layout: bits [11:10] carry the class index.
package qos_pkg;

  localparam int NCLASS = 4;
  localparam int DATA_W = 12;
  localparam int PESO_W = 3;
  localparam int CLS_HI = 11;
  localparam int CLS_LO = 10;

  typedef logic [1:0] cls_t;

  function automatic cls_t cls_of(input logic [DATA_W-1:0] word);
    return word[CLS_HI:CLS_LO];
  endfunction

  // A zero weight would starve its class, so it is promoted to 1.
  function automatic logic [PESO_W-1:0] peso_eff(input logic [PESO_W-1:0] peso);
    return (peso == '0) ? PESO_W'(1) : peso;
  endfunction

endpackage

// File: rtl/qos_rr_select.sv
// Finds the first non-empty class FIFO after ptr, wrapping round to ptr itself last.
module qos_rr_select
  import qos_pkg::*;
(
  input  logic [1:0]        ptr,
  input  logic [NCLASS-1:0] fifo_empty,
  output logic              found,
  output logic [1:0]        next_ptr
);

  logic [1:0] idx;

  // Walk from farthest to nearest so the nearest non-empty class wins.
  always_comb begin
    found    = 1'b0;
    next_ptr = ptr;
    idx      = ptr;
    for (int k = NCLASS; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (!fifo_empty[idx]) begin
        found    = 1'b1;
        next_ptr = idx;
      end
    end
  end

endmodule

// File: rtl/qos_arbitro_salida.sv
// Weighted round-robin drain of four class FIFOs into the single output FIFO.
// Pops are combinational; the word is pushed one cycle later when the FIFO read data is valid.
module qos_arbitro_salida
  import qos_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              enable,
  input  logic [PESO_W-1:0] peso0,
  input  logic [PESO_W-1:0] peso1,
  input  logic [PESO_W-1:0] peso2,
  input  logic [PESO_W-1:0] peso3,
  input  logic [NCLASS-1:0] fifo_empty,
  input  logic [DATA_W-1:0] fifo_dataout0,
  input  logic [DATA_W-1:0] fifo_dataout1,
  input  logic [DATA_W-1:0] fifo_dataout2,
  input  logic [DATA_W-1:0] fifo_dataout3,
  input  logic              out_almost_full,
  output logic [NCLASS-1:0] fifo_pop,
  output logic [DATA_W-1:0] data_out,
  output logic              push_out,
  output logic [1:0]        grant_cls,
  output logic [7:0]        cuenta_total
);

  logic [PESO_W-1:0] peso_q [NCLASS];
  logic [PESO_W-1:0] credit_q, credit_d;
  logic [1:0]        ptr_q, ptr_d, sel, sel_q;
  logic              pop, pop_q, pop_ok;
  logic              found;
  logic [1:0]        next_ptr;
  logic [DATA_W-1:0] rd_data [NCLASS];
  logic [DATA_W-1:0] data_hold_q;
  logic [7:0]        cnt_q;

  assign rd_data[0] = fifo_dataout0;
  assign rd_data[1] = fifo_dataout1;
  assign rd_data[2] = fifo_dataout2;
  assign rd_data[3] = fifo_dataout3;

  qos_rr_select u_sel (
    .ptr        (ptr_q),
    .fifo_empty (fifo_empty),
    .found      (found),
    .next_ptr   (next_ptr)
  );

  assign pop_ok = reset & ~init & enable & ~out_almost_full;

  always_comb begin
    ptr_d    = ptr_q;
    credit_d = credit_q;
    sel      = ptr_q;
    pop      = 1'b0;
    if (pop_ok) begin
      if (!fifo_empty[ptr_q] && credit_q != '0) begin
        pop      = 1'b1;
        credit_d = credit_q - 1'b1;
      end else if (found) begin
        pop      = 1'b1;
        sel      = next_ptr;
        ptr_d    = next_ptr;
        credit_d = peso_q[next_ptr] - 1'b1;
      end
    end
  end

  assign fifo_pop = pop ? ({{(NCLASS-1){1'b0}}, 1'b1} << sel) : '0;

  // Gating with reset drops a word whose pop preceded a reset cycle.
  assign push_out     = pop_q & reset;
  assign data_out     = push_out ? rd_data[sel_q] : data_hold_q;
  assign grant_cls    = ptr_q;
  assign cuenta_total = cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NCLASS; i++) peso_q[i] <= PESO_W'(1);
      credit_q    <= PESO_W'(1);
      ptr_q       <= '0;
      sel_q       <= '0;
      pop_q       <= 1'b0;
      data_hold_q <= '0;
      cnt_q       <= '0;
    end else begin
      if (init) begin
        peso_q[0] <= peso_eff(peso0);
        peso_q[1] <= peso_eff(peso1);
        peso_q[2] <= peso_eff(peso2);
        peso_q[3] <= peso_eff(peso3);
        ptr_q     <= '0;
        credit_q  <= peso_eff(peso0);
      end else begin
        ptr_q    <= ptr_d;
        credit_q <= credit_d;
      end
      pop_q <= pop;
      sel_q <= sel;
      if (push_out) begin
        data_hold_q <= rd_data[sel_q];
        cnt_q       <= cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_qos_arbitro_salida.sv
// Bench for qos_arbitro_salida: pop-qualification vector table plus multi-cycle
// sequences against behavioural class FIFOs.
module tb_qos_arbitro_salida;
  import qos_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, init, enable, out_almost_full;
  logic [2:0]  peso0, peso1, peso2, peso3;
  logic [3:0]  fifo_empty, tbl_empty, mdl_empty;
  logic [11:0] dq [4] = '{default: 12'h000};
  logic [11:0] tbl_data [4];
  logic [11:0] dout [4];
  logic        model_on;
  logic [3:0]  fifo_pop;
  logic [11:0] data_out;
  logic        push_out;
  logic [1:0]  grant_cls;
  logic [7:0]  cuenta_total;

  assign fifo_empty = model_on ? mdl_empty : tbl_empty;
  always_comb for (int i = 0; i < 4; i++) dout[i] = model_on ? dq[i] : tbl_data[i];

  qos_arbitro_salida dut (
    .clk(clk), .reset(reset), .init(init), .enable(enable),
    .peso0(peso0), .peso1(peso1), .peso2(peso2), .peso3(peso3),
    .fifo_empty(fifo_empty),
    .fifo_dataout0(dout[0]), .fifo_dataout1(dout[1]),
    .fifo_dataout2(dout[2]), .fifo_dataout3(dout[3]),
    .out_almost_full(out_almost_full),
    .fifo_pop(fifo_pop), .data_out(data_out), .push_out(push_out),
    .grant_cls(grant_cls), .cuenta_total(cuenta_total)
  );

  // Behavioural class FIFOs: read data valid the cycle after a pop.
  logic [11:0] fq [4][$];
  logic [3:0]  pop_seen = 4'b0000;
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (model_on && pop_seen[i] && fq[i].size() != 0) dq[i] <= fq[i].pop_front();
      mdl_empty[i] <= (fq[i].size() == 0);
    end
  end

  function automatic int enc(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  int cyc = 0, multi_pop = 0, underflow = 0;
  int pop_log[$], pop_cyc[$], push_cyc[$];
  logic [11:0] push_log[$];

  always @(negedge clk) begin
    cyc++;
    pop_seen = fifo_pop;
    if (!$onehot0(fifo_pop)) multi_pop++;
    if ((fifo_pop & fifo_empty) != 4'b0000) underflow++;
    if (fifo_pop != 4'b0000) begin
      pop_log.push_back(enc(fifo_pop));
      pop_cyc.push_back(cyc);
    end
    if (push_out) begin
      push_log.push_back(data_out);
      push_cyc.push_back(cyc);
    end
  end

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    pop_log.delete(); pop_cyc.delete(); push_log.delete(); push_cyc.delete();
    multi_pop = 0; underflow = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic wait_pops(input int n, input int maxc, input string nm);
    int c = 0;
    while (pop_log.size() < n && c < maxc) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk({nm, " pop count"}, pop_log.size(), n);
  endtask

  task automatic load(input int c, input logic [11:0] base, input int n);
    for (int k = 0; k < n; k++) fq[c].push_back(base + 12'(k));
  endtask

  typedef struct packed {
    logic [3:0]  empty;
    logic        en;
    logic        af;
    logic        ini;
    logic [3:0]  exp_pop;
    logic [1:0]  exp_grant;
    logic [11:0] exp_data;
  } vec_t;

  vec_t tbl [11];
  logic [11:0] heads [4];
  int seq_c [24];
  int seq_d [16];
  int seq_f [6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    heads = '{12'h024, 12'h54A, 12'hAAA, 12'hFAF};
    tbl[0]  = '{4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 12'h000};
    tbl[1]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0001, 2'd0, 12'h024};
    tbl[2]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 4'b0010, 2'd1, 12'h54A};
    tbl[3]  = '{4'b1011, 1'b1, 1'b0, 1'b0, 4'b0100, 2'd2, 12'hAAA};
    tbl[4]  = '{4'b0111, 1'b1, 1'b0, 1'b0, 4'b1000, 2'd3, 12'hFAF};
    tbl[5]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 12'h000};
    tbl[6]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, 12'h000};
    tbl[7]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 2'd0, 12'h000};
    tbl[8]  = '{4'b1110, 1'b1, 1'b0, 1'b0, 4'b0001, 2'd0, 12'h024};
    tbl[9]  = '{4'b0101, 1'b1, 1'b0, 1'b0, 4'b0010, 2'd1, 12'h54A};
    tbl[10] = '{4'b1010, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 12'h000};
    seq_c = '{0,0,0,1,1,2,3, 0,0,0,1,1,2,3, 1,1,2,3,2,3,2,3,2,3};
    seq_d = '{0,0,0, 1,1,2,3,0,1,1,2,3,2,3,2,3};
    seq_f = '{0,1,0,1,0,1};

    reset = 1'b0; init = 1'b0; enable = 1'b0; out_almost_full = 1'b0;
    peso0 = 3'd0; peso1 = 3'd0; peso2 = 3'd0; peso3 = 3'd0;
    model_on = 1'b1; tbl_empty = 4'b1111;
    for (int i = 0; i < 4; i++) tbl_data[i] = heads[i];

    // Reset state, then idle with everything empty
    repeat (3) tick();
    @(negedge clk); #1;
    chk("rst fifo_pop", fifo_pop, 4'b0000);
    chk("rst push_out", push_out, 1'b0);
    chk("rst data_out", data_out, 12'h000);
    chk("rst grant_cls", grant_cls, 2'd0);
    chk("rst cuenta", cuenta_total, 8'd0);
    tick();
    reset = 1'b1; enable = 1'b1;
    clear_logs();
    repeat (20) begin @(negedge clk); #1; end
    chk("idle pops", pop_log.size(), 0);
    chk("idle pushes", push_log.size(), 0);
    chk("idle cuenta", cuenta_total, 8'd0);

    // Pop qualification table, each vector from a fresh reset
    model_on = 1'b0;
    for (int v = 0; v < 11; v++) begin
      enable = 1'b0;
      do_reset();
      tbl_empty = tbl[v].empty; enable = tbl[v].en;
      out_almost_full = tbl[v].af; init = tbl[v].ini;
      @(negedge clk); #1;
      chk($sformatf("vec%0d fifo_pop", v), fifo_pop, tbl[v].exp_pop);
      tick();
      enable = 1'b0; init = 1'b0; out_almost_full = 1'b0; tbl_empty = 4'b1111;
      @(negedge clk); #1;
      chk($sformatf("vec%0d grant_cls", v), grant_cls, tbl[v].exp_grant);
      chk($sformatf("vec%0d push_out", v), push_out, tbl[v].exp_pop != 4'b0000);
      chk($sformatf("vec%0d data_out", v), data_out, tbl[v].exp_data);
    end

    // Default weights: plain round robin over four backlogged classes
    model_on = 1'b1;
    enable = 1'b0;
    do_reset();
    for (int c = 0; c < 4; c++) load(c, heads[c], 4);
    tick();
    clear_logs();
    enable = 1'b1;
    wait_pops(16, 60, "rr");
    repeat (3) tick();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("rr pop%0d", i), pop_log[i], i % 4);
      chk($sformatf("rr data%0d", i), push_log[i], heads[i % 4] + 12'(i / 4));
    end
    chk("rr push count", push_log.size(), 16);
    chk("rr first push latency", push_cyc[0], pop_cyc[0] + 1);
    chk("rr cuenta", cuenta_total, 8'd16);

    // Weights 3,2,1,1 with six words per class
    enable = 1'b0;
    for (int c = 0; c < 4; c++) load(c, heads[c], 6);
    peso0 = 3'd3; peso1 = 3'd2; peso2 = 3'd1; peso3 = 3'd1;
    init = 1'b1;
    tick();
    init = 1'b0;
    clear_logs();
    enable = 1'b1;
    wait_pops(24, 80, "wrr");
    repeat (3) tick();
    for (int i = 0; i < 24; i++) chk($sformatf("wrr pop%0d", i), pop_log[i], seq_c[i]);
    chk("wrr multi pop", multi_pop, 0);
    chk("wrr underflow", underflow, 0);
    chk("wrr cuenta", cuenta_total, 8'd40);

    // Back-pressure for five cycles after the third pop
    enable = 1'b0;
    for (int c = 0; c < 4; c++) load(c, heads[c], 4);
    tick();
    clear_logs();
    enable = 1'b1;
    wait_pops(3, 20, "bp pre");
    tick();
    out_almost_full = 1'b1;
    begin
      int q0, p0;
      q0 = pop_log.size();
      p0 = push_log.size();
      repeat (5) @(negedge clk);
      tick();
      chk("bp pops during", pop_log.size() - q0, 0);
      chk("bp trailing pushes", push_log.size() - p0, 1);
    end
    out_almost_full = 1'b0;
    wait_pops(16, 60, "bp");
    repeat (3) tick();
    for (int i = 0; i < 16; i++) chk($sformatf("bp pop%0d", i), pop_log[i], seq_d[i]);
    chk("bp cuenta", cuenta_total, 8'd56);

    // Only class 2 backlogged, ptr at 0 after init with zero weights
    enable = 1'b0;
    peso0 = 3'd0; peso1 = 3'd0; peso2 = 3'd0; peso3 = 3'd0;
    load(2, 12'h800, 3);
    init = 1'b1;
    tick();
    init = 1'b0;
    clear_logs();
    enable = 1'b1;
    wait_pops(3, 20, "solo2");
    repeat (10) tick();
    chk("solo2 total pops", pop_log.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("solo2 pop%0d", i), pop_log[i], 2);
      chk($sformatf("solo2 data%0d", i), push_log[i], 12'h800 + 12'(i));
    end
    chk("solo2 grant_cls", grant_cls, 2'd2);
    chk("solo2 underflow", underflow, 0);
    chk("solo2 cuenta", cuenta_total, 8'd59);

    // Reset right after a pop: word dropped, weights back to 1
    enable = 1'b0;
    peso0 = 3'd1; peso1 = 3'd3; peso2 = 3'd1; peso3 = 3'd1;
    load(0, 12'h030, 4);
    load(1, 12'h460, 3);
    init = 1'b1;
    tick();
    init = 1'b0;
    clear_logs();
    enable = 1'b1;
    wait_pops(1, 10, "rstmid");
    chk("rstmid first pop", pop_log[0], 0);
    tick();
    reset = 1'b0;
    @(negedge clk); #1;
    chk("rstmid push_out", push_out, 1'b0);
    tick();
    @(negedge clk); #1;
    chk("rstmid fifo_pop", fifo_pop, 4'b0000);
    chk("rstmid push_out2", push_out, 1'b0);
    chk("rstmid data_out", data_out, 12'h000);
    chk("rstmid grant_cls", grant_cls, 2'd0);
    chk("rstmid cuenta", cuenta_total, 8'd0);
    chk("rstmid no push", push_log.size(), 0);
    tick();
    reset = 1'b1;
    clear_logs();
    wait_pops(6, 30, "postrst");
    for (int i = 0; i < 6; i++) chk($sformatf("postrst pop%0d", i), pop_log[i], seq_f[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/qos_arbitro_salida.md
Name: qos_arbitro_salida

Overview:
- Downstream stage of the QoS demux block.
- Drains the four per-class (VC) FIFOs with weighted round-robin arbitration and forwards 12-bit words into the single output FIFO.
- Honours output back-pressure and the FSM enable (active state).
- Drives the pops that the bench currently issues by hand (popBP0..3).

Parameters:
- DATA_W, 12, word width (bits [11:10] = class)
- NCLASS, 4, number of class FIFOs (fixed; ptr logic is 2-bit)
- PESO_W, 3, weight field width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low; 0 = reset
- init  in  1  config phase; latch weights, hold pops off
- enable  in  1  from FSM active_out; 0 = no new pops
- peso0..peso3  in  3 each  per-class weights, sampled while init=1
- fifo_empty  in  4  empty flags of class FIFOs 0..3
- fifo_dataout0..3  in  12 each  class FIFO read data, valid 1 cycle after pop
- out_almost_full  in  1  output FIFO back-pressure; asserted with >=1 free slot
- fifo_pop  out  4  one-hot pop to class FIFOs
- data_out  out  12  word to output FIFO
- push_out  out  1  write strobe to output FIFO
- grant_cls  out  2  class currently holding the grant pointer
- cuenta_total  out  8  words forwarded since reset, wraps 255->0

Behaviour:
- Reset (reset=0 at posedge), all outputs 0:
  - fifo_pop=0, push_out=0, data_out=0, grant_cls=0, cuenta_total=0.
  - Internal weights = 1 each (plain RR), credit = 1, ptr = 0.
  - Reset mid-transfer drops any in-flight word; no push follows.
- init=1 (priority over arbitration):
  - Latch peso_i into weight regs; weight 0 is stored as 1.
  - ptr=0, credit=weight0.
  - fifo_pop=0; a pending push from the prior cycle still completes.
- Pop qualification: pop allowed in cycle N iff reset=1, init=0, enable=1, out_almost_full=0, and the selected class has fifo_empty=0.
  - At most one fifo_pop bit high per cycle.
- Selection:
  - If class ptr is non-empty and credit>0, pop ptr; credit--.
  - Else search ptr+1, ptr+2, ptr+3, ptr (wrap mod 4) for the first non-empty class, move ptr there, reload credit=weight, and pop it in the same cycle (credit = weight-1 after).
  - All empty: no pop, ptr and credit held.
- Credit exhaustion: credit reaching 0 forces the search on the next cycle even if ptr is still non-empty. Result: exactly weight_i consecutive pops per turn when all classes are backlogged.
- Datapath, latency 1:
  - pop of class i in cycle N gives data_out=fifo_dataout_i and push_out=1 in cycle N+1.
  - data_out holds its last value when push_out=0.
- cuenta_total increments on every push_out=1.
- enable falling or out_almost_full rising in cycle N: no pop in N; a pop issued in N-1 still pushes in N (hence the required 1-slot margin).
- A FIFO going empty on the popped word: the next cycle sees fifo_empty=1 and searches; no underflow pop is ever issued.
- grant_cls = ptr, registered.

Decomposition:
- Shared package qos_pkg:
  - constants NCLASS=4, DATA_W=12, PESO_W=3
  - class field slice [11:10]
  - encoding of class index (2-bit)
- One sub-module, qos_rr_select: combinational next-non-empty search.
  - Inputs: ptr, fifo_empty. Outputs: found, next_ptr.
  - Instantiated once; the credit and pipeline registers stay in the top.

Test Plan:
- Reset hold then release, all FIFOs empty, enable=1 -> fifo_pop=0, push_out=0, cuenta_total=0 for 20 cycles.
- Default weights (no init), 4 words each in classes 0..3 ('h024,'h54A,'hAAA,'hFAF heads) -> pop order 0,1,2,3,0,1,2,3...; first push_out one cycle after first pop with data_out='h024; cuenta_total=16 at end.
- init with pesos 3,2,1,1, all classes backlogged with 6 words -> pop sequence 0,0,0,1,1,2,3,0,0,0,...; never two pops in one cycle.
- out_almost_full asserted for 5 cycles mid-stream -> pops stop the same cycle; exactly one trailing push; resume order continues from held ptr/credit.
- Only class 2 non-empty (3 words), ptr=0 -> search jumps to 2; 3 consecutive pops; grant_cls=2; no pop when fifo_empty[2] rises.
- reset=0 asserted the cycle after a pop -> no push_out next cycle; all outputs 0; weights back to 1.
